// File: rtl/bitwise_seq_pkg.sv
// rtl/bitwise_seq_pkg.sv - op and FSM state encodings for bitwise_seq_unit
package bitwise_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// rtl/bitwise_slice.sv - combinational SLICE-bit AND/OR/XOR/NAND datapath
module bitwise_slice
    import bitwise_seq_pkg::*;
#(
    parameter int SLICE = 4
)
(
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  op_t              op,
    output logic [SLICE-1:0] y_s
);

    // Select the logic function for one slice.
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            default: y_s = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_seq_unit.sv
// rtl/bitwise_seq_unit.sv - sliced sequential bitwise unit; optional zr flag under BITWISE_SEQ_ZR_EN
module bitwise_seq_unit
    import bitwise_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef BITWISE_SEQ_ZR_EN
    ,
    output logic             zr
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] y_s;
    logic             last;

    assign last = (cnt == CW'(NSLICE - 1));
    assign a_s  = a_q[32'(cnt) * SLICE +: SLICE];
    assign b_s  = b_q[32'(cnt) * SLICE +: SLICE];
    assign out  = res;

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .a_s (a_s),
        .b_s (b_s),
        .op  (op_q),
        .y_s (y_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: one RUN cycle per slice, DONE waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last)      state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on acceptance, then one result slice written per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_AND;
            cnt  <= '0;
            res  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op_t'(op);
                        cnt  <= '0;
                        res  <= '0;
                    end
                end
                ST_RUN: begin
                    res[32'(cnt) * SLICE +: SLICE] <= y_s;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BITWISE_SEQ_ZR_EN
    // Zero flag accumulated slice by slice, so it is ready together with the result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zr <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            zr <= 1'b1;
        end else if (state == ST_RUN) begin
            zr <= zr & ~|y_s;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// tb/tb_bitwise_seq_unit.sv - scoreboard bench for bitwise_seq_unit (SLICE=4 and SLICE=16)
module tb_bitwise_seq_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, out;
    logic [1:0]  op;
    logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1;
    logic [15:0] a_1, b_1, out_1;
    logic [1:0]  op_1;
`ifdef BITWISE_SEQ_ZR_EN
    logic        zr, zr_1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic        zr;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    bitwise_seq_unit #(.WIDTH(16), .SLICE(4)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef BITWISE_SEQ_ZR_EN
        ,
        .zr        (zr)
`endif
    );

    bitwise_seq_unit #(.WIDTH(16), .SLICE(16)) u_dut_1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .a         (a_1),
        .b         (b_1),
        .op        (op_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .out       (out_1)
`ifdef BITWISE_SEQ_ZR_EN
        ,
        .zr        (zr_1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic [1:0] mop);
        case (mop)
            2'b00:   return ma & mb;
            2'b01:   return ma | mb;
            2'b10:   return ma ^ mb;
            default: return ~(ma & mb);
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [15:0] ma, input logic [15:0] mb, input logic [1:0] mop);
        exp_t e;
        e.res = model(ma, mb, mop);
        e.zr  = (e.res == 16'h0000);
        return e;
    endfunction

    // Full operation on the SLICE=4 unit; edges counted with the accepting edge as 1.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                         input int bp, input bit change_a);
        int   edges;
        bit   ready_leak;
        exp_t e;
        logic [15:0] held;
        @(negedge clock);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        sb.push_back(make_exp(ta, tb, top));
        @(posedge clock); #1;
        edges = 1;
        ready_leak = 1'b0;
        in_valid = 1'b0;
        if (change_a) a = 16'hFFFF;
        while (!out_valid && edges < 40) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge clock); #1;
            edges++;
        end
        check("latency", 32'(edges), 32'd5);
        check("busy_in_ready", 32'(ready_leak), 32'd0);
        held = out;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 2'($urandom);
            @(posedge clock); #1;
            check("bp_out_stable", 32'(out), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("result", 32'(out), 32'(e.res));
`ifdef BITWISE_SEQ_ZR_EN
            check("zr", 32'(zr), 32'(e.zr));
`endif
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("post_done_valid", 32'(out_valid), 32'd0);
        check("post_done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        exp_t e;
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        in_valid_1 = 1'b0; out_ready_1 = 1'b0; a_1 = '0; b_1 = '0; op_1 = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst1_in_ready", 32'(in_ready_1), 32'd1);
`ifdef BITWISE_SEQ_ZR_EN
        check("rst_zr", 32'(zr), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        do_op(16'hF0F0, 16'hFF00, 2'b00, 0, 1'b0);
        do_op(16'hAAAA, 16'h5555, 2'b10, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 2'b11, 0, 1'b0);
        do_op(16'h1234, 16'h00FF, 2'b01, 6, 1'b0);
        do_op(16'h0F00, 16'h00F0, 2'b01, 0, 1'b1);

        // Reset after two slices have been written: operation is discarded.
        @(negedge clock);
        a = 16'h5A5A; b = 16'hFFFF; op = 2'b00; in_valid = 1'b1;
        sb.push_back(make_exp(16'h5A5A, 16'hFFFF, 2'b00));
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        e = sb.pop_back();
        @(negedge clock);
        reset_n = 1'b1;
        do_op(16'hC3C3, 16'h0FF0, 2'b00, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op(16'($urandom), 16'($urandom), 2'(i), 0, 1'b0);
        end

        // Single-slice configuration.
        @(negedge clock);
        a_1 = 16'h1234; b_1 = 16'hFFFF; op_1 = 2'b00; in_valid_1 = 1'b1;
        sb.push_back(make_exp(16'h1234, 16'hFFFF, 2'b00));
        @(posedge clock); #1;
        edges = 1;
        in_valid_1 = 1'b0;
        while (!out_valid_1 && edges < 40) begin
            @(posedge clock); #1;
            edges++;
        end
        check("s16_latency", 32'(edges), 32'd2);
        out_ready_1 = 1'b1;
        if (sb.size() == 0) begin
            check("sb_underflow_1", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("s16_result", 32'(out_1), 32'(e.res));
`ifdef BITWISE_SEQ_ZR_EN
            check("s16_zr", 32'(zr_1), 32'(e.zr));
`endif
        end
        @(posedge clock); #1;
        out_ready_1 = 1'b0;
        check("s16_post_valid", 32'(out_valid_1), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
